// File: rtl/uart_lite_axi_slave.sv
// AXI4-Lite register front-end for a byte-stream UART PHY: RX/TX FIFOs, status and control.
// Read and write channels run independently and meet only at the FIFO state.

module uart_lite_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       dropped
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

module uart_lite_axi_slave #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        INTR
);
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       strb;
    } wr_req_t;

    rd_state_t   rd_state;
    wr_req_t     wr_req;
    logic        aw_held, w_held, wr_commit;
    logic        ctrl_ie, overrun;
    logic        ar_hs, rx_pop, stat_rd;
    logic        tx_push, tx_clr, rx_clr;
    logic        rx_empty, rx_full, rx_drop, tx_empty, tx_full, tx_drop_unused;
    logic [7:0]  rx_head;
    logic [31:0] stat, rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{ARADDR[1:0], AWADDR[1:0], WDATA[31:8], WSTRB[3:1], tx_drop_unused};

    assign RRESP = 2'b00;
    assign BRESP = 2'b00;

    assign ar_hs     = ARVALID & ARREADY;
    assign rx_pop    = ar_hs & (ARADDR[3:2] == 2'd0);
    assign stat_rd   = ar_hs & (ARADDR[3:2] == 2'd2);
    assign wr_commit = aw_held & w_held;
    assign tx_push   = wr_commit & (wr_req.sel == 2'd1) & wr_req.strb;
    assign tx_clr    = wr_commit & (wr_req.sel == 2'd3) & wr_req.data[0];
    assign rx_clr    = wr_commit & (wr_req.sel == 2'd3) & wr_req.data[1];
    assign TX_VALID  = ~tx_empty;

    assign stat = {26'b0, overrun, ctrl_ie, tx_full, tx_empty, rx_full, ~rx_empty};

    uart_lite_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx (
        .CLK(CLK), .RST(RST), .clr(rx_clr), .push(RX_VALID), .pop(rx_pop),
        .din(RX_DATA), .dout(rx_head), .empty(rx_empty), .full(rx_full), .dropped(rx_drop)
    );

    uart_lite_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx (
        .CLK(CLK), .RST(RST), .clr(tx_clr), .push(tx_push), .pop(TX_READY),
        .din(wr_req.data), .dout(TX_DATA), .empty(tx_empty), .full(tx_full), .dropped(tx_drop_unused)
    );

    always_comb begin
        rd_mux = '0;
        case (ARADDR[3:2])
            2'd0:    rd_mux = {24'b0, rx_empty ? 8'h00 : rx_head};
            2'd2:    rd_mux = stat;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_state <= R_IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RDATA    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (ARVALID) begin
                    RDATA    <= rd_mux;
                    RVALID   <= 1'b1;
                    ARREADY  <= 1'b0;
                    rd_state <= R_RESP;
                end
                R_RESP: if (RREADY) begin
                    RVALID   <= 1'b0;
                    ARREADY  <= 1'b1;
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // A fresh overrun in the same cycle as a STAT read must survive the read-clear.
    always_ff @(posedge CLK) begin
        if (RST)          overrun <= 1'b0;
        else if (rx_drop) overrun <= 1'b1;
        else if (stat_rd) overrun <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b0;
            wr_req  <= '0;
            ctrl_ie <= 1'b0;
            INTR    <= 1'b0;
        end else begin
            INTR <= (~rx_empty | tx_empty) & ctrl_ie;
            if (AWVALID && AWREADY) begin
                aw_held    <= 1'b1;
                wr_req.sel <= AWADDR[3:2];
                AWREADY    <= 1'b0;
            end
            if (WVALID && WREADY) begin
                w_held      <= 1'b1;
                wr_req.data <= WDATA[7:0];
                wr_req.strb <= WSTRB[0];
                WREADY      <= 1'b0;
            end
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                if (wr_req.sel == 2'd3) ctrl_ie <= wr_req.data[4];
            end
            // Readies stay low until the response is taken: one write in flight at most.
            if (BVALID && BREADY) begin
                BVALID  <= 1'b0;
                AWREADY <= 1'b1;
                WREADY  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_lite_axi_slave.sv
// Directed-plus-random bench for uart_lite_axi_slave against a queue-based register model.
module tb_uart_lite_axi_slave;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  ARADDR, AWADDR;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] RDATA, WDATA;
    logic [1:0]  RRESP, BRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;
    logic [7:0]  TX_DATA, RX_DATA;
    logic        TX_VALID, TX_READY, RX_VALID, INTR;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovr, m_ie;

    always #5 CLK = ~CLK;

    uart_lite_axi_slave #(.FIFO_DEPTH(DEPTH), .PTR_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .INTR(INTR)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s    = '0;
        s[0] = (rx_q.size() != 0);
        s[1] = (rx_q.size() == DEPTH);
        s[2] = (tx_q.size() == 0);
        s[3] = (tx_q.size() == DEPTH);
        s[4] = m_ie;
        s[5] = m_ovr;
        return s;
    endfunction

    task automatic m_reset();
        tx_q.delete();
        rx_q.delete();
        m_ovr = 1'b0;
        m_ie  = 1'b0;
    endtask

    task automatic axi_read(input logic [1:0] sel, input int stall, output logic [31:0] got);
        logic [31:0] exp, held;
        int n;
        n = 0;
        while (!ARREADY && n < 20) begin step(); n++; end
        chk("arready_idle", ARREADY, 1);
        exp = '0;
        if (sel == 2'd0 && rx_q.size() != 0) exp = {24'b0, rx_q.pop_front()};
        if (sel == 2'd2) begin exp = m_stat(); m_ovr = 1'b0; end
        ARADDR  = {sel, 2'($urandom)};
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("rvalid_after_ar", RVALID, 1);
        chk($sformatf("rdata_reg%0d", sel), RDATA, exp);
        chk("rresp", RRESP, 0);
        chk("arready_busy", ARREADY, 0);
        held = RDATA;
        got  = RDATA;
        repeat (stall) begin
            step();
            chk("rvalid_stall", RVALID, 1);
            chk("rdata_stall", RDATA, held);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        chk("rvalid_done", RVALID, 0);
        chk("arready_back", ARREADY, 1);
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [1:0] sel, input logic [7:0] data, input logic strb,
                             input int lead, input bit take_b);
        int t, n, aw_t, w_t;
        bit aw_done, w_done, aw_hs, w_hs;
        aw_t = (lead > 0) ? lead : 0;
        w_t  = (lead < 0) ? -lead : 0;
        AWADDR = {sel, 2'($urandom)};
        WDATA  = {24'($urandom), data};
        WSTRB  = {3'($urandom), strb};
        t = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && t < 20) begin
            AWVALID = !aw_done && (t >= aw_t);
            WVALID  = !w_done && (t >= w_t);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            step();
            t++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (w_done && !aw_done) chk("wready_dropped", WREADY, 0);
            if (aw_done && !w_done) chk("awready_dropped", AWREADY, 0);
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("aw_w_accepted", {31'b0, aw_done && w_done}, 1);
        n = 0;
        while (!BVALID && n < 10) begin step(); n++; end
        chk("bvalid", BVALID, 1);
        chk("bresp", BRESP, 0);
        case (sel)
            2'd1: if (strb && tx_q.size() < DEPTH) tx_q.push_back(data);
            2'd3: begin
                if (data[0]) tx_q.delete();
                if (data[1]) rx_q.delete();
                m_ie = data[4];
            end
            default: ;
        endcase
        if (take_b) begin
            step();
            chk("bvalid_held", BVALID, 1);
            BREADY = 1'b1;
            step();
            BREADY = 1'b0;
            chk("bvalid_single", BVALID, 0);
            chk("awready_back", AWREADY, 1);
            chk("wready_back", WREADY, 1);
        end
    endtask

    task automatic tx_drain(input int cycles);
        TX_READY = 1'b1;
        repeat (cycles) begin
            if (tx_q.size() != 0) begin
                chk("tx_valid", TX_VALID, 1);
                chk("tx_data", TX_DATA, tx_q.pop_front());
            end else begin
                chk("tx_valid_empty", TX_VALID, 0);
            end
            step();
        end
        TX_READY = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        step();
        RX_VALID = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic chk_intr();
        step();
        chk("intr", INTR, ((rx_q.size() != 0) || (tx_q.size() == 0)) && m_ie);
    endtask

    initial begin
        logic [31:0] r;
        RST = 1'b1;
        ARADDR = '0; ARVALID = 0; RREADY = 0;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        TX_READY = 0; RX_DATA = '0; RX_VALID = 0;
        m_reset();
        step();
        step();
        chk("rst_arready", ARREADY, 1);
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 1);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_intr", INTR, 0);
        chk("rst_tx_valid", TX_VALID, 0);
        RST = 1'b0;
        step();

        axi_read(2'd2, 3, r);
        chk("stat_after_reset", r, 32'h4);

        axi_write(2'd1, 8'h41, 1'b1, 2, 1'b1);
        chk("tx_valid_41", TX_VALID, 1);
        chk("tx_data_41", TX_DATA, 8'h41);
        axi_read(2'd2, 0, r);
        chk("stat_tx_one", r, 32'h0);
        tx_drain(1);
        axi_read(2'd2, 0, r);
        chk("stat_tx_drained", r, 32'h4);

        for (int i = 0; i < 17; i++)
            axi_write(2'd1, 8'($urandom), 1'b1, $urandom_range(0, 4) - 2, 1'b1);
        axi_read(2'd2, 1, r);
        chk("stat_tx_full_bit", r[3], 1);
        tx_drain(DEPTH + 3);

        axi_read(2'd1, 0, r);
        axi_read(2'd3, 2, r);
        axi_write(2'd0, 8'hFF, 1'b1, -1, 1'b1);
        axi_write(2'd2, 8'hFF, 1'b1, 0, 1'b1);
        axi_write(2'd1, 8'h99, 1'b0, 1, 1'b1);
        chk("strb0_ignored", TX_VALID, 0);

        rx_push(8'h55);
        rx_push(8'hAA);
        for (int i = 0; i < 3; i++) axi_read(2'd0, $urandom_range(0, 2), r);
        axi_read(2'd2, 0, r);
        chk("rx_empty_after_reads", r[0], 0);

        axi_write(2'd1, 8'($urandom), 1'b1, 0, 1'b1);
        for (int i = 0; i < 17; i++) rx_push(8'($urandom));
        axi_read(2'd2, 0, r);
        chk("stat_overrun", r, 32'h23);
        axi_read(2'd2, 0, r);
        chk("stat_overrun_cleared", r, 32'h03);
        for (int i = 0; i < 17; i++) axi_read(2'd0, 0, r);

        rx_push(8'($urandom));
        rx_push(8'($urandom));
        axi_write(2'd1, 8'($urandom), 1'b1, -2, 1'b1);
        axi_write(2'd3, 8'h13, 1'b1, 1, 1'b1);
        axi_read(2'd2, 0, r);
        chk("stat_ctrl_clear", r, 32'h14);
        chk_intr();
        rx_push(8'h5A);
        axi_write(2'd1, 8'h77, 1'b1, 0, 1'b1);
        chk_intr();
        axi_write(2'd3, 8'h00, 1'b1, 0, 1'b1);
        chk_intr();

        axi_write(2'd3, 8'h10, 1'b1, 0, 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        m_reset();
        chk("bvalid_after_rst", BVALID, 0);
        chk("intr_after_rst", INTR, 0);
        chk("awready_after_rst", AWREADY, 1);
        repeat (3) step();
        chk("no_late_bvalid", BVALID, 0);
        axi_read(2'd2, 0, r);
        chk("stat_after_mid_rst", r, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_lite_axi_slave.md
Name: uart_lite_axi_slave

Overview:
AXI4-Lite responder that terminates the core's UART register accesses: RX FIFO at 0x0, TX FIFO at 0x4, STAT at 0x8, CTRL at 0xC.
- Buffers bytes between the bus and an external bit-level serializer/deserializer through byte-stream ports.
- Sits between the core's in/out bus master and the UART PHY in the top-level design.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2.
PTR_W, 4, log2(FIFO_DEPTH); sizes read/write pointers, with counts one bit wider.

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
ARADDR  in  4  read address; bits [3:2] select register, [1:0] ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response, always 2'b00
RVALID  out  1  read data valid
RREADY  in  1  read data ready
AWADDR  in  4  write address; bits [3:2] select register
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes; only bit 0 is used
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response, always 2'b00
BVALID  out  1  write response valid
BREADY  in  1  write response ready
TX_DATA  out  8  byte toward the serializer (TX FIFO head)
TX_VALID  out  1  TX FIFO not empty
TX_READY  in  1  serializer takes byte; pop when TX_VALID&TX_READY
RX_DATA  in  8  byte from the deserializer
RX_VALID  in  1  one-cycle push strobe into the RX FIFO
INTR  out  1  registered: (STAT[0] | STAT[2]) & CTRL[4]

Behaviour:
Reset (RST=1 at an edge):
- Both FIFOs are emptied; overrun and CTRL[4] are cleared.
- ARREADY=1, AWREADY=1, WREADY=1.
- RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0, INTR=0.
- Reset mid-transaction abandons the transaction; no response is issued afterwards.

Read channel:
- States R_IDLE, R_RESP.
- R_IDLE: ARREADY=1. On ARVALID&ARREADY at edge N, RDATA is registered from the selected register's state as of cycle N. RVALID=1 from N+1, ARREADY=0, go to R_RESP.
- R_RESP: hold RDATA and RVALID until RVALID&RREADY, then go to R_IDLE with ARREADY=1 the next cycle. Maximum throughput is one read per 2 cycles.
- Register 0x0: RDATA={24'b0, RX head}, and the RX FIFO pops at edge N. If the RX FIFO is empty, RDATA=0 and there is no pop.
- Register 0x4 and 0xC: read as 0.
- Register 0x8 (STAT):
  - [0] RX not empty
  - [1] RX full
  - [2] TX empty
  - [3] TX full
  - [4] CTRL[4]
  - [5] overrun
  - [31:6] 0
  - The read clears overrun at edge N, unless a new overrun occurs in the same cycle, in which case overrun stays 1.

Write channel:
- AW and W are accepted independently, in either order or in the same cycle.
- Each ready drops for the cycle after its handshake, and the address/data is latched.
- The write commits in the cycle where both are held, and BVALID=1 the next cycle.
- BVALID holds until BVALID&BREADY. AWREADY and WREADY return to 1 only after the B handshake, so at most one write is outstanding.
- 0x4 with WSTRB[0]=1: push WDATA[7:0] into the TX FIFO. If TX is full and there is no TX pop that cycle, the byte is dropped; BRESP is still OKAY.
- 0xC:
  - bit0=1 empties the TX FIFO.
  - bit1=1 empties the RX FIFO.
  - bit4 is stored as the interrupt enable.
  - Bits 0 and 1 are self-clearing and read as 0.
- 0x0 and 0x8: writes are ignored; the response is still OKAY.

FIFOs (circular, pointers wrap modulo FIFO_DEPTH, counts PTR_W+1 bits):
- Simultaneous push and pop: both occur; count is unchanged.
- Push into a full FIFO with a simultaneous pop: accepted.
- RX push into a full FIFO with no pop: byte dropped, overrun set to 1.
- CTRL FIFO reset in the same cycle as a push or pop: the reset wins and the FIFO ends empty.
- Read and write paths operate concurrently; they share only FIFO state.

Test Plan:
- Reset, then read 0x8 -> RDATA=0x00000004, RVALID on the cycle after the AR handshake, held while RREADY=0 for 3 cycles.
- Write 0x41 to 0x4 with W presented 2 cycles before AW, TX_READY=0 -> single BVALID; TX_VALID=1, TX_DATA=0x41; STAT=0x0; after one TX_READY cycle, STAT=0x4.
- 17 writes to 0x4 with TX_READY=0, FIFO_DEPTH=16 -> STAT[3]=1; TX_DATA sequence after draining equals the first 16 bytes; the 17th byte is absent.
- Push 0x55,0xAA on RX_VALID, then read 0x0 three times -> RDATA 0x55, 0xAA, 0x00; STAT[0]=0 afterwards.
- 17 RX pushes, then read 0x8 twice -> first read 0x23, second read 0x03; RX FIFO contents unchanged by the STAT reads.
- Write 0x13 to 0xC with both FIFOs non-empty -> STAT=0x14; INTR=1 (TX empty, enable set); raise RST mid-B-phase -> BVALID=0 the next cycle.
